// File: rtl/eth_speed_detect.sv
// PHY link-speed / link-presence detector: counts edges of a synchronized, divided
// RX clock per reference window. Optional forced speed via ETH_SPEED_DETECT_FORCE_EN.
module eth_speed_detect #(
  parameter int SYNC_STAGES   = 3,
  parameter int WINDOW_WIDTH  = 8,
  parameter int THRESH_1000M  = 40,
  parameter int THRESH_100M   = 6,
  parameter int CONFIRM_COUNT = 2,
  parameter int LOSS_COUNT    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_div_in,
`ifdef ETH_SPEED_DETECT_FORCE_EN
  input  logic                    force_en,
  input  logic [1:0]              force_speed,
`endif
  output logic [1:0]              speed,
  output logic                    mii_select,
  output logic                    link_up,
  output logic                    speed_change,
  output logic [WINDOW_WIDTH-1:0] edge_count
);

  localparam int MW = $clog2(CONFIRM_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam logic [MW-1:0]           CONF  = MW'(CONFIRM_COUNT);
  localparam logic [LW-1:0]           LOSS  = LW'(LOSS_COUNT);
  localparam logic [WINDOW_WIDTH-1:0] T1000 = WINDOW_WIDTH'(THRESH_1000M);
  localparam logic [WINDOW_WIDTH-1:0] T100  = WINDOW_WIDTH'(THRESH_100M);

  // Class codes share the speed encoding so a confirmed class loads speed directly.
  localparam logic [1:0] C10 = 2'b00, C100 = 2'b01, C1000 = 2'b10, CNONE = 2'b11;

  typedef enum logic [1:0] {DOWN, CHECK, UP} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [WINDOW_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [WINDOW_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [1:0]              last_class_q, last_class_d;
  logic [MW-1:0]           match_cnt_q, match_cnt_d;
  logic [LW-1:0]           loss_cnt_q, loss_cnt_d;
  logic [1:0]              speed_q, speed_d;
  logic                    mii_q, mii_d;
  logic                    link_q, link_d;
  logic                    sc_q, sc_d;
  logic [WINDOW_WIDTH-1:0] edge_count_q, edge_count_d;

  logic                    rx_edge, terminal, confirmed, lost;
  logic [WINDOW_WIDTH-1:0] total;
  logic [1:0]              cls;

  // Measurement datapath
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rx_div_in};
    rx_edge    = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];
    terminal   = &win_cnt_q;
    win_cnt_d  = win_cnt_q + 1'b1;
    total      = (&edge_cnt_q) ? edge_cnt_q
                               : edge_cnt_q + {{(WINDOW_WIDTH-1){1'b0}}, rx_edge};
    edge_cnt_d = terminal ? '0 : total;
    if (total >= T1000)                  cls = C1000;
    else if (total >= T100)              cls = C100;
    else if (total != '0)                cls = C10;
    else                                 cls = CNONE;
  end

  // Hysteresis and loss tracking, updated on terminal cycles only
  always_comb begin
    last_class_d = last_class_q;
    match_cnt_d  = match_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    if (terminal) begin
      if (cls == CNONE) begin
        if (loss_cnt_q != LOSS) loss_cnt_d = loss_cnt_q + 1'b1;
      end else begin
        loss_cnt_d = '0;
        if (cls == last_class_q) begin
          if (match_cnt_q != CONF) match_cnt_d = match_cnt_q + 1'b1;
        end else begin
          last_class_d = cls;
          match_cnt_d  = MW'(1);
        end
      end
    end
    confirmed = terminal && (cls != CNONE) && (match_cnt_d == CONF);
    lost      = terminal && (loss_cnt_d == LOSS);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DOWN;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (terminal) begin
      case (state_q)
        DOWN:    if (cls != CNONE) state_d = CHECK;
        CHECK:   if (cls == CNONE) state_d = DOWN;
                 else if (confirmed) state_d = UP;
        UP:      if (lost) state_d = DOWN;
        default: state_d = DOWN;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    speed_d = speed_q;
    link_d  = link_q;
    case (state_q)
      CHECK: if (confirmed) begin
        link_d  = 1'b1;
        speed_d = last_class_d;
      end
      UP: begin
        if (lost)
          link_d = 1'b0;
        else if (confirmed && (last_class_d != speed_q))
          speed_d = last_class_d;
      end
      default: ;
    endcase
`ifdef ETH_SPEED_DETECT_FORCE_EN
    if (force_en) speed_d = (force_speed == 2'b11) ? 2'b10 : force_speed;
`endif
    mii_d        = (speed_d != 2'b10);
    sc_d         = (speed_d != speed_q);
    edge_count_d = terminal ? total : edge_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      last_class_q <= C10;
      match_cnt_q  <= '0;
      loss_cnt_q   <= '0;
      speed_q      <= 2'b10;
      mii_q        <= 1'b0;
      link_q       <= 1'b0;
      sc_q         <= 1'b0;
      edge_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      last_class_q <= last_class_d;
      match_cnt_q  <= match_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      speed_q      <= speed_d;
      mii_q        <= mii_d;
      link_q       <= link_d;
      sc_q         <= sc_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign speed        = speed_q;
  assign mii_select   = mii_q;
  assign link_up      = link_q;
  assign speed_change = sc_q;
  assign edge_count   = edge_count_q;

endmodule

// File: tb/tb_eth_speed_detect.sv
// Randomized bench for eth_speed_detect: a per-window reference model derives the
// expected edge count, class, link and speed from the recorded input history.
module tb_eth_speed_detect;
  localparam int SS = 3, WW = 8, T1K = 40, T100 = 6, CONF = 2, LOSS = 2;
  localparam int WIN = 1 << WW;

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic          rx_div_in = 1'b0;
  logic          force_en = 1'b0;
  logic [1:0]    force_speed = 2'b00;
  logic [1:0]    speed;
  logic          mii_select, link_up, speed_change;
  logic [WW-1:0] edge_count;

  eth_speed_detect #(
    .SYNC_STAGES(SS), .WINDOW_WIDTH(WW), .THRESH_1000M(T1K), .THRESH_100M(T100),
    .CONFIRM_COUNT(CONF), .LOSS_COUNT(LOSS)
  ) dut (
    .clk(gclk), .rst_n(grst_n), .rx_div_in(rx_div_in),
`ifdef ETH_SPEED_DETECT_FORCE_EN
    .force_en(force_en), .force_speed(force_speed),
`endif
    .speed(speed), .mii_select(mii_select), .link_up(link_up),
    .speed_change(speed_change), .edge_count(edge_count)
  );

  always #5 gclk = ~gclk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int ph = 0;
  bit hist [0:32767];

  // Reference state: per-window view of the detector (state 0=down, 1=check, 2=up)
  int m_last = -1, m_match = 0, m_loss = 0, m_state = 0;
  int m_speed = 2, m_link = 0, m_edges = 0;
  bit m_changed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic bit hv(input int i);
    return (i <= 0) ? 1'b0 : hist[i];
  endfunction

  // An input change sampled on posedge m is seen as an edge SS-2 cycles later.
  task automatic model_window(input int w);
    int cnt, cls, prev;
    cnt = 0;
    prev = m_speed;
    for (int k = 0; k < WIN; k++) begin
      int m;
      m = WIN * w + k;
      if (hv(m - SS + 2) != hv(m - SS + 1)) cnt++;
    end
    if (cnt > WIN - 1) cnt = WIN - 1;
    cls = (cnt >= T1K) ? 2 : (cnt >= T100) ? 1 : (cnt >= 1) ? 0 : 3;
    if (cls == 3) m_loss = (m_loss < LOSS) ? m_loss + 1 : LOSS;
    else begin
      m_loss = 0;
      if (cls == m_last) m_match = (m_match < CONF) ? m_match + 1 : CONF;
      else begin m_last = cls; m_match = 1; end
    end
    case (m_state)
      0: if (cls != 3) m_state = 1;
      1: if (cls == 3) m_state = 0;
         else if (m_match == CONF) begin m_state = 2; m_link = 1; m_speed = m_last; end
      default: if (m_loss == LOSS) begin m_state = 0; m_link = 0; end
               else if (cls != 3 && m_match == CONF) m_speed = m_last;
    endcase
    m_edges = cnt;
    m_changed = (m_speed != prev);
  endtask

  task automatic step(input logic v);
    rx_div_in = v;
    @(posedge gclk);
    cyc++;
    hist[cyc] = v;
    @(negedge gclk);
    if (cyc % WIN == 0) begin
      model_window(cyc / WIN - 1);
      chk("edge_count", edge_count, m_edges);
      chk("speed", speed, m_speed);
      chk("mii_select", mii_select, (m_speed != 2));
      chk("link_up", link_up, m_link);
    end
    chk("speed_change", speed_change, (cyc % WIN == 0) && m_changed);
  endtask

  // period>0: periodic toggling; nexact>0: exactly n toggles early in the window;
  // nexact<0: five early toggles plus one landing on the terminal cycle.
  task automatic run_window(input int period, input int nexact);
    for (int k = 0; k < WIN; k++) begin
      int pos;
      bit tog;
      pos = (cyc + 1) % WIN;
      tog = 1'b0;
      if (period > 0)      tog = ((cyc + 1 + ph) % period == 0);
      else if (nexact > 0) tog = (pos >= 4 && pos < 4 + 5 * nexact && (pos - 4) % 5 == 0);
      else if (nexact < 0) tog = (pos == WIN + 1 - SS) ||
                                 (pos >= 4 && pos < 4 + 5 * 5 && (pos - 4) % 5 == 0);
      step(rx_div_in ^ tog);
    end
  endtask

  task automatic run_n(input int n, input int period, input int nexact);
    for (int i = 0; i < n; i++) run_window(period, nexact);
  endtask

  initial begin
    int periods [13] = '{0, 1, 2, 3, 4, 5, 8, 20, 30, 45, 60, 100, 200};
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    chk("rst_speed", speed, 2);
    chk("rst_mii", mii_select, 0);
    chk("rst_link", link_up, 0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_speed_change", speed_change, 0);

    run_n(4, 0, 0);          // idle line
    run_n(4, 4, 0);          // 1000M rate
    run_n(4, 20, 0);         // 100M rate
    run_n(4, 200, 0);        // 10M rate
    run_n(3, 20, 0);
    run_n(1, 4, 0);          // single noisy window
    run_n(2, 20, 0);
    run_n(1, 0, 0);          // one dead window
    run_n(1, 20, 0);
    run_n(2, 0, 0);          // link loss
    run_n(3, 20, 0);
    run_n(3, 0, 5);          // just below 100M threshold
    run_n(3, 0, 6);          // exactly at threshold
    run_n(3, 0, -1);         // edge on terminal cycle
    for (int i = 0; i < 40; i++) begin
      ph = $urandom_range(0, 199);
      if ($urandom_range(0, 2) == 0) run_window(0, $urandom_range(0, 45));
      else run_window(periods[$urandom_range(0, 12)], 0);
    end
    ph = 0;
    run_n(3, 4, 0);

`ifdef ETH_SPEED_DETECT_FORCE_EN
    force_speed = 2'b00;
    force_en = 1'b1;
    @(posedge gclk); @(negedge gclk);
    chk("force_speed", speed, 0);
    chk("force_mii", mii_select, 1);
    chk("force_speed_change", speed_change, (m_speed != 0));
    chk("force_link", link_up, m_link);
    @(posedge gclk); @(negedge gclk);
    chk("force_hold_change", speed_change, 0);
    chk("force_hold_speed", speed, 0);
`endif

    #2 grst_n = 1'b0;
    #1;
    chk("async_rst_speed", speed, 2);
    chk("async_rst_mii", mii_select, 0);
    chk("async_rst_link", link_up, 0);
    chk("async_rst_edge_count", edge_count, 0);
    chk("async_rst_speed_change", speed_change, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
